ped_request_unit: RTL and testbench
===================================

PED_REQUEST_UNIT -- requirements
Module: ped_request_unit

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 4, SHALL set consecutive stable cycles (>=2) needed to accept a button level change.
REQ-002 Parameter LOCKOUT_CYC, default 20, SHALL set cycles (>=1) after a served request during which new presses are ignored.
REQ-003 Ports SHALL be, one per line: name  direction  width  meaning.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (reset=0 at a rising edge resets the block).
REQ-006 btn_raw  input  1  asynchronous, bouncing pedestrian push-button, 1=pressed.
REQ-007 walk_ack  input  1  from the traffic light controller, 1 while the pedestrian (crosswalk green) phase is granted.
REQ-008 ped_req  output  1  registered pedestrian request to the traffic light controller.
REQ-009 btn_clean  output  1  registered debounced button level.
REQ-010 lock_busy  output  1  registered, 1 while in SERVE or LOCKOUT.
REQ-011 press_cnt  output  8  registered count of debounced presses, saturating at 255.

Function
REQ-012 btn_raw SHALL pass a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-013 Debounce counter SHALL increment at each edge where sync2 != btn_clean, and clear to 0 at each edge where sync2 == btn_clean.
REQ-014 At an edge where sync2 != btn_clean and counter == DEBOUNCE_CYC-1, btn_clean SHALL toggle and counter SHALL clear.
REQ-015 Latency: btn_raw high stable before edge E -> btn_clean=1 after edge E+1+DEBOUNCE_CYC; release is symmetric.
REQ-016 Any btn_raw pulse or gap shorter than DEBOUNCE_CYC sampled cycles SHALL NOT change btn_clean.
REQ-017 A press SHALL be a one-cycle internal event when btn_clean rises (btn_clean=1, previous btn_clean=0); falling edges are not presses.
REQ-018 press_cnt SHALL increment by 1 on every press in any state, holding at 255 (no wrap).
REQ-019 FSM states SHALL be IDLE, REQ, SERVE, LOCKOUT.
REQ-020 IDLE: press -> REQ at next edge; walk_ack ignored.
REQ-021 REQ: ped_req=1; stay until walk_ack=1 sampled, then -> SERVE at that edge; further presses ignored (counted only).
REQ-022 SERVE: ped_req=0, lock_busy=1; when walk_ack=0 sampled -> LOCKOUT with lockout counter loaded to 0.
REQ-023 LOCKOUT: lockout counter increments each edge; on edge where counter == LOCKOUT_CYC-1 -> IDLE; presses ignored; walk_ack ignored.
REQ-024 ped_req SHALL rise at the edge after btn_clean rises (E+2+DEBOUNCE_CYC) and fall at the edge walk_ack=1 is sampled.
REQ-025 Press and walk_ack=1 in the same IDLE cycle: press wins -> REQ; walk_ack then acts in REQ.
REQ-026 A press in the last LOCKOUT cycle SHALL be ignored; the button held through lockout SHALL NOT re-request (new rising edge required).
REQ-027 Lockout counter width SHALL be ceil(log2(LOCKOUT_CYC))+1 bits; no overflow possible.

Reset
REQ-028 reset=0 at an edge SHALL set state IDLE, sync1=sync2=0, btn_clean=0, both counters 0, ped_req=0, lock_busy=0, press_cnt=0, regardless of state or inputs.
REQ-029 Reset mid-request SHALL drop ped_req the edge reset is sampled; a button held through reset SHALL be re-debounced and count as a new press after reset releases.

Verification
REQ-030 DEBOUNCE_CYC=4: btn_raw 0->1 before edge 10, held -> btn_clean=1 after edge 15, ped_req=1 after edge 16, press_cnt=1.
REQ-031 btn_raw bounces 1,0,1,0 on single cycles then stays 0 -> btn_clean, ped_req, press_cnt remain 0.
REQ-032 In REQ, walk_ack=1 for 8 cycles then 0 -> ped_req falls at first ack edge, lock_busy=1 for 8+LOCKOUT_CYC cycles, then IDLE.
REQ-033 Clean press during LOCKOUT -> no ped_req, press_cnt increments; clean press after lockout -> ped_req rises.
REQ-034 reset=0 for one edge while ped_req=1 -> all outputs 0 next cycle; button held -> ped_req re-asserts DEBOUNCE_CYC+2 edges after reset release, press_cnt=1.
REQ-035 300 clean presses -> press_cnt=255, no wrap.

Source files
------------

// File: rtl/ped_request_unit.sv
// Pedestrian push-button front end: synchronizes and debounces the raw button,
// counts presses and runs the request/serve/lockout handshake with the light controller.
module ped_request_unit #(
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned LOCKOUT_CYC  = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       walk_ack,
    output logic       ped_req,
    output logic       btn_clean,
    output logic       lock_busy,
    output logic [7:0] press_cnt
);

    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYC) + 1;
    localparam int unsigned LOCK_W = $clog2(LOCKOUT_CYC) + 1;
    localparam int unsigned CNT_W  = 8;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVE   = 2'd2;
    localparam logic [1:0] ST_LOCKOUT = 2'd3;

    logic              sync1_q;
    logic              sync2_q;
    logic              clean_q;
    logic              clean_d;
    logic              clean_prev_q;
    logic [DEB_W-1:0]  deb_cnt_q;
    logic [DEB_W-1:0]  deb_cnt_d;
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [LOCK_W-1:0] lock_cnt_q;
    logic [LOCK_W-1:0] lock_cnt_d;
    logic              ped_req_q;
    logic              ped_req_d;
    logic              lock_busy_q;
    logic              lock_busy_d;
    logic [CNT_W-1:0]  press_cnt_q;
    logic [CNT_W-1:0]  press_cnt_d;
    logic              press_c;

    // A press is the rising edge of the debounced level only.
    assign press_c = clean_q & ~clean_prev_q;

    // Debounce: count consecutive cycles where the synchronized level disagrees.
    always_comb begin
        deb_cnt_d = '0;
        clean_d   = clean_q;
        if (sync2_q != clean_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                clean_d = ~clean_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    always_comb begin
        press_cnt_d = press_cnt_q;
        if (press_c && (press_cnt_q != CNT_MAX)) begin
            press_cnt_d = press_cnt_q + CNT_W'(1);
        end
    end

    // Request handshake; outputs are decoded from the next state so they register with it.
    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = lock_cnt_q;
        ped_req_d   = 1'b0;
        lock_busy_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (press_c) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (walk_ack) begin
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (!walk_ack) begin
                    state_d    = ST_LOCKOUT;
                    lock_cnt_d = '0;
                end
            end
            ST_LOCKOUT: begin
                if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                lock_cnt_d = '0;
            end
        endcase
        ped_req_d   = (state_d == ST_REQ);
        lock_busy_d = (state_d == ST_SERVE) || (state_d == ST_LOCKOUT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            clean_q      <= 1'b0;
            clean_prev_q <= 1'b0;
            deb_cnt_q    <= '0;
            press_cnt_q  <= '0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            clean_q      <= clean_d;
            clean_prev_q <= clean_q;
            deb_cnt_q    <= deb_cnt_d;
            press_cnt_q  <= press_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            lock_cnt_q  <= '0;
            ped_req_q   <= 1'b0;
            lock_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            ped_req_q   <= ped_req_d;
            lock_busy_q <= lock_busy_d;
        end
    end

    assign ped_req   = ped_req_q;
    assign btn_clean = clean_q;
    assign lock_busy = lock_busy_q;
    assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_ped_request_unit.sv
// Directed vector bench for ped_request_unit (DEBOUNCE_CYC=4, LOCKOUT_CYC=20).
module tb_ped_request_unit;

    logic       clk;
    logic       reset;
    logic       btn_raw;
    logic       walk_ack;
    logic       ped_req;
    logic       btn_clean;
    logic       lock_busy;
    logic [7:0] press_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rst;
        logic       btn;
        logic       ack;
        int         cyc;
        logic       e_req;
        logic       e_clean;
        logic       e_busy;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    ped_request_unit #(
        .DEBOUNCE_CYC(4),
        .LOCKOUT_CYC (20)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .walk_ack (walk_ack),
        .ped_req  (ped_req),
        .btn_clean(btn_clean),
        .lock_busy(lock_busy),
        .press_cnt(press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic b, input logic a, input int c,
                       input logic q, input logic cl, input logic bz, input logic [7:0] n);
        vec_t v;
        v.rst = r; v.btn = b; v.ack = a; v.cyc = c;
        v.e_req = q; v.e_clean = cl; v.e_busy = bz; v.e_cnt = n;
        vecs.push_back(v);
    endtask

    task automatic check_outs(input string nm, input int idx,
                              input logic q, input logic cl, input logic bz, input logic [7:0] n);
        checks++;
        if ({ped_req, btn_clean, lock_busy, press_cnt} !== {q, cl, bz, n}) begin
            errors++;
            $display("FAIL %s%0d: got req=%b clean=%b busy=%b cnt=%0d, expected req=%b clean=%b busy=%b cnt=%0d",
                     nm, idx, ped_req, btn_clean, lock_busy, press_cnt, q, cl, bz, n);
        end
    endtask

    task automatic run_cycles(input logic r, input logic b, input logic a, input int c);
        @(negedge clk);
        reset    = r;
        btn_raw  = b;
        walk_ack = a;
        repeat (c) @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        btn_raw  = 1'b0;
        walk_ack = 1'b0;

        // rst btn ack cyc | req clean busy cnt
        add(0, 0, 0,  3,  0, 0, 0, 0);
        // clean press: btn_clean after 6 edges, ped_req after 7
        add(1, 1, 0,  4,  0, 0, 0, 0);
        add(1, 1, 0,  1,  0, 0, 0, 0);
        add(1, 1, 0,  1,  0, 1, 0, 0);
        add(1, 1, 0,  1,  1, 1, 0, 1);
        add(1, 1, 0,  5,  1, 1, 0, 1);
        // ack for 8 cycles, then 20 lockout cycles
        add(1, 1, 1,  1,  0, 1, 1, 1);
        add(1, 1, 1,  7,  0, 1, 1, 1);
        add(1, 1, 0,  1,  0, 1, 1, 1);
        add(1, 1, 0, 19,  0, 1, 1, 1);
        add(1, 1, 0,  1,  0, 1, 0, 1);
        add(1, 1, 1,  2,  0, 1, 0, 1);
        // release
        add(1, 0, 0,  5,  0, 1, 0, 1);
        add(1, 0, 0,  1,  0, 0, 0, 1);
        // single-cycle bounces
        add(1, 1, 0,  1,  0, 0, 0, 1);
        add(1, 0, 0,  1,  0, 0, 0, 1);
        add(1, 1, 0,  1,  0, 0, 0, 1);
        add(1, 0, 0, 10,  0, 0, 0, 1);
        // press during lockout is counted but not requested
        add(1, 1, 0,  6,  0, 1, 0, 1);
        add(1, 1, 0,  1,  1, 1, 0, 2);
        add(1, 0, 1,  1,  0, 1, 1, 2);
        add(1, 0, 1,  5,  0, 0, 1, 2);
        add(1, 0, 0,  1,  0, 0, 1, 2);
        add(1, 1, 0,  6,  0, 1, 1, 2);
        add(1, 1, 0,  1,  0, 1, 1, 3);
        add(1, 1, 0, 12,  0, 1, 1, 3);
        add(1, 1, 0,  1,  0, 1, 0, 3);
        add(1, 0, 0,  6,  0, 0, 0, 3);
        add(1, 1, 0,  6,  0, 1, 0, 3);
        add(1, 1, 0,  1,  1, 1, 0, 4);
        // reset mid-request with button held
        add(0, 1, 0,  1,  0, 0, 0, 0);
        add(1, 1, 0,  6,  0, 1, 0, 0);
        add(1, 1, 0,  1,  1, 1, 0, 1);
        add(1, 1, 1,  1,  0, 1, 1, 1);
        add(1, 1, 0,  1,  0, 1, 1, 1);
        add(1, 1, 0, 19,  0, 1, 1, 1);
        add(1, 1, 0,  1,  0, 1, 0, 1);
        // press and ack in the same idle cycle
        add(1, 0, 0,  6,  0, 0, 0, 1);
        add(1, 1, 0,  6,  0, 1, 0, 1);
        add(1, 1, 1,  1,  1, 1, 0, 2);
        add(1, 1, 1,  1,  0, 1, 1, 2);
        add(1, 1, 0, 21,  0, 1, 0, 2);
        // press landing in the last lockout cycle
        add(1, 0, 0,  6,  0, 0, 0, 2);
        add(1, 1, 0,  6,  0, 1, 0, 2);
        add(1, 1, 0,  1,  1, 1, 0, 3);
        add(1, 0, 1,  6,  0, 0, 1, 3);
        add(1, 0, 0,  1,  0, 0, 1, 3);
        add(1, 0, 0, 13,  0, 0, 1, 3);
        add(1, 1, 0,  5,  0, 0, 1, 3);
        add(1, 1, 0,  1,  0, 1, 1, 3);
        add(1, 1, 0,  1,  0, 1, 0, 4);
        add(1, 1, 0,  3,  0, 1, 0, 4);
        // release gaps of 1 and 3 cycles are filtered
        add(1, 0, 0,  1,  0, 1, 0, 4);
        add(1, 1, 0,  8,  0, 1, 0, 4);
        add(1, 0, 0,  3,  0, 1, 0, 4);
        add(1, 1, 0,  8,  0, 1, 0, 4);

        foreach (vecs[i]) begin
            run_cycles(vecs[i].rst, vecs[i].btn, vecs[i].ack, vecs[i].cyc);
            check_outs("vec", i, vecs[i].e_req, vecs[i].e_clean, vecs[i].e_busy, vecs[i].e_cnt);
        end

        // Saturation: 300 clean presses from reset, no ack so the FSM parks in REQ.
        run_cycles(0, 0, 0, 2);
        check_outs("sat_reset", 0, 0, 0, 0, 8'd0);
        for (int p = 0; p < 300; p++) begin
            run_cycles(1, 1, 0, 7);
            run_cycles(1, 0, 0, 7);
            if (p == 9)   check_outs("sat_cnt", p + 1, 1, 0, 0, 8'd10);
            if (p == 253) check_outs("sat_cnt", p + 1, 1, 0, 0, 8'd254);
            if (p == 254) check_outs("sat_cnt", p + 1, 1, 0, 0, 8'd255);
        end
        check_outs("sat_cnt", 300, 1, 0, 0, 8'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
